dct8_bfly_sched: RTL and testbench

//  Sequencer that time-shares one registered butterfly PE across all pair operations of an 8-point in-place DCT pass.
//  - Generates dual-port read addresses into the 8-entry sample memory.
//  - Drives the butterfly enable.
//  - Generates write-back addresses, stage by stage.
//  - Sits between the top-level DCT8 control (start/done) and the memory + butterfly datapath.

---
 rtl/dct8_bfly_sched_pkg.sv | 22 ++
 rtl/dct8_pair_gen.sv | 28 ++
 rtl/dct8_bfly_sched.sv | 123 ++++++++++++
 tb/tb_dct8_bfly_sched.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dct8_bfly_sched_pkg.sv
// Shared constants and types for the 8-point DCT butterfly scheduler.
// Holds the FSM encoding and the delay-line entry layout.
package dct8_bfly_sched_pkg;

    localparam int unsigned DCT8_N      = 8;
    localparam int unsigned DCT8_PAIRS  = 4;
    localparam int unsigned DCT8_ADDR_W = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic                   valid;
        logic [DCT8_ADDR_W-1:0] a;
        logic [DCT8_ADDR_W-1:0] b;
    } pipe_t;

endpackage

// File: rtl/dct8_pair_gen.sv
// Combinational (stage, pair) -> (a, b) address map for the in-place 8-point butterfly network.
module dct8_pair_gen
    import dct8_bfly_sched_pkg::*;
(
    input  logic [1:0]             stage,
    input  logic [1:0]             k,
    output logic [DCT8_ADDR_W-1:0] addr_a,
    output logic [DCT8_ADDR_W-1:0] addr_b
);

    always_comb begin
        // Stage 0: one block of 8, pairs mirror around the centre.
        addr_a = {1'b0, k};
        addr_b = DCT8_ADDR_W'(DCT8_N - 1) - {1'b0, k};
        case (stage)
            2'd1: begin
                addr_a = {k[1], 1'b0, k[0]};
                addr_b = {k[1], 1'b1, ~k[0]};
            end
            2'd2: begin
                addr_a = {k, 1'b0};
                addr_b = {k, 1'b1};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dct8_bfly_sched.sv
// Sequencer time-sharing one registered butterfly across all pair operations of an
// 8-point in-place DCT pass: read issue, butterfly enable and delayed write-back.
module dct8_bfly_sched
    import dct8_bfly_sched_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned BF_LAT     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stall,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             stage,
    output logic                   rd_en,
    output logic [DCT8_ADDR_W-1:0] rd_addr_a,
    output logic [DCT8_ADDR_W-1:0] rd_addr_b,
    output logic                   bf_enable,
    output logic                   wr_en,
    output logic [DCT8_ADDR_W-1:0] wr_addr_a,
    output logic [DCT8_ADDR_W-1:0] wr_addr_b
);

    localparam int unsigned DLY = MEM_LAT + BF_LAT;
    localparam int unsigned DW  = $clog2(DLY + 1);

    state_t                 state_q, state_d;
    logic [1:0]             k_q, k_d;
    logic [1:0]             stage_q, stage_d;
    logic [DW-1:0]          drain_q, drain_d;
    pipe_t                  pipe_q [DLY];
    logic [DCT8_ADDR_W-1:0] pair_a, pair_b;

    dct8_pair_gen u_pair_gen (
        .stage  (stage_q),
        .k      (k_q),
        .addr_a (pair_a),
        .addr_b (pair_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            stage_q <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            stage_q <= stage_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        stage_d = stage_q;
        drain_d = drain_q;
        if (!stall) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_ISSUE;
                        stage_d = '0;
                        k_d     = '0;
                    end
                end
                S_ISSUE: begin
                    k_d = k_q + 2'd1;
                    if (k_q == 2'(DCT8_PAIRS - 1)) begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end
                end
                S_DRAIN: begin
                    // Wait out the read+butterfly latency so the next stage sees landed writes.
                    if (drain_q == DW'(DLY - 1)) begin
                        if (stage_q == 2'(NUM_STAGES - 1)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_ISSUE;
                            stage_d = stage_q + 2'd1;
                            k_d     = '0;
                        end
                    end else begin
                        drain_d = drain_q + DW'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    stage_d = '0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign rd_en     = (state_q == S_ISSUE) && !stall;
    assign rd_addr_a = rd_en ? pair_a : '0;
    assign rd_addr_b = rd_en ? pair_b : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DLY); i++) pipe_q[i] <= '0;
        end else if (!stall) begin
            pipe_q[0] <= {rd_en, rd_addr_a, rd_addr_b};
            for (int i = 1; i < int'(DLY); i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign bf_enable = pipe_q[MEM_LAT-1].valid && !stall;
    assign wr_en     = pipe_q[DLY-1].valid && !stall;
    assign wr_addr_a = pipe_q[DLY-1].a;
    assign wr_addr_b = pipe_q[DLY-1].b;

    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);
    assign stage = stage_q;

endmodule

// File: tb/tb_dct8_bfly_sched.sv
// Directed bench for dct8_bfly_sched: timing, stall, start handling, reset and a
// memory + butterfly model whose final contents are compared with hand-computed results.
module tb_dct8_bfly_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start1 = 1'b0;
    logic       stall = 1'b0;
    logic       load = 1'b0;

    logic       busy, done, rd_en, bf_enable, wr_en;
    logic [1:0] stage;
    logic [2:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;

    logic       busy1, done1, rd_en1, bf_enable1, wr_en1;
    logic [1:0] stage1;
    logic [2:0] rd_addr_a1, rd_addr_b1, wr_addr_a1, wr_addr_b1;

    int total = 0;
    int bad = 0;

    // Read-pair index issued in each cycle of an unstalled default pass (-1: none).
    int rd_idx [24] = '{-1, 0, 1, 2, 3, -1, -1, 4, 5, 6, 7, -1, -1, 8, 9, 10, 11,
                        -1, -1, -1, -1, -1, -1, -1};
    int exp_a [12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
    int exp_b [12] = '{7, 6, 5, 4, 3, 2, 7, 6, 1, 3, 5, 7};
    int gold  [8]  = '{28, 0, 0, 0, -16, 0, 8, -4};

    logic signed [15:0] mem [8];
    logic signed [15:0] rda, rdb, bs, bd;

    always #5 clk = ~clk;

    dct8_bfly_sched dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .stage     (stage),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .bf_enable (bf_enable),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b)
    );

    dct8_bfly_sched #(.NUM_STAGES(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start1),
        .stall     (stall),
        .busy      (busy1),
        .done      (done1),
        .stage     (stage1),
        .rd_en     (rd_en1),
        .rd_addr_a (rd_addr_a1),
        .rd_addr_b (rd_addr_b1),
        .bf_enable (bf_enable1),
        .wr_en     (wr_en1),
        .wr_addr_a (wr_addr_a1),
        .wr_addr_b (wr_addr_b1)
    );

    // Sample memory (1-cycle read, data held while rd_en low) and registered butterfly.
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 8; i++) mem[i] <= 16'(i);
        end else if (wr_en) begin
            mem[wr_addr_a] <= bs;
            mem[wr_addr_b] <= bd;
        end
        if (rd_en) begin
            rda <= mem[rd_addr_a];
            rdb <= mem[rd_addr_b];
        end
        if (bf_enable) begin
            bs <= rda + rdb;
            bd <= rda - rdb;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full default pass with an optional stall window [lo,hi]; checks every cycle and memory.
    task automatic run_pass(input string nm, input int lo, input int hi);
        int n, sh, e, er, eb, ew;
        sh = (hi >= lo) ? (hi - lo + 1) : 0;
        n  = 20 + sh;
        @(negedge clk); load = 1'b1;
        @(negedge clk); load = 1'b0; start = 1'b1;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            start = 1'b0;
            stall = (c >= lo) && (c <= hi);
            #1;
            if (stall)     e = -1;
            else if (c < lo) e = c;
            else           e = c - sh;
            er = (e >= 1) ? rd_idx[e] : -1;
            eb = (e >= 2) ? rd_idx[e-1] : -1;
            ew = (e >= 3) ? rd_idx[e-2] : -1;
            chk($sformatf("%s rd_en c%0d", nm, c), 32'(rd_en), 32'(er >= 0));
            if (er >= 0) begin
                chk($sformatf("%s rd_a c%0d", nm, c), 32'(rd_addr_a), exp_a[er]);
                chk($sformatf("%s rd_b c%0d", nm, c), 32'(rd_addr_b), exp_b[er]);
            end
            chk($sformatf("%s bf_en c%0d", nm, c), 32'(bf_enable), 32'(eb >= 0));
            chk($sformatf("%s wr_en c%0d", nm, c), 32'(wr_en), 32'(ew >= 0));
            if (ew >= 0) begin
                chk($sformatf("%s wr_a c%0d", nm, c), 32'(wr_addr_a), exp_a[ew]);
                chk($sformatf("%s wr_b c%0d", nm, c), 32'(wr_addr_b), exp_b[ew]);
            end
            chk($sformatf("%s done c%0d", nm, c), 32'(done), 32'(e == 19));
            chk($sformatf("%s busy c%0d", nm, c), 32'(busy),
                32'(stall || (e >= 1 && e <= 19)));
            if (e >= 1 && e <= 18)
                chk($sformatf("%s stage c%0d", nm, c), 32'(stage), (e - 1) / 6);
        end
        stall = 1'b0;
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s mem%0d", nm, i), 32'(mem[i]), gold[i]);
    endtask

    initial begin
        #1;
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst rd_en", 32'(rd_en), 0);
        chk("rst rd_b", 32'(rd_addr_b), 0);
        chk("rst wr_en", 32'(wr_en), 0);
        chk("rst busy1", 32'(busy1), 0);
        @(negedge clk);
        @(negedge clk); rst = 1'b0;

        // Plain pass, then same pass with a 3-cycle stall starting at cycle 3.
        run_pass("pass", 100, 0);
        run_pass("stall", 3, 5);

        // start held high: back-to-back passes separated by a single idle cycle.
        @(negedge clk); start = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk); #1;
            chk($sformatf("held done c%0d", c), 32'(done), 32'(c == 19));
            if (c == 20) chk("held idle gap", 32'(busy), 0);
            if (c == 21) begin
                chk("held restart rd_en", 32'(rd_en), 1);
                chk("held restart rd_a", 32'(rd_addr_a), 0);
                chk("held restart rd_b", 32'(rd_addr_b), 7);
            end
        end
        start = 1'b0;
        begin
            int w;
            w = 0;
            while (busy && w < 40) begin
                @(negedge clk); #1;
                w++;
            end
            chk("held drain timeout", 32'(busy), 0);
        end

        // Reset in the middle of a pass.
        @(negedge clk); start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk); start = 1'b0;
        end
        rst = 1'b1; #1;
        chk("mid rst busy", 32'(busy), 0);
        chk("mid rst done", 32'(done), 0);
        chk("mid rst stage", 32'(stage), 0);
        chk("mid rst rd_en", 32'(rd_en), 0);
        chk("mid rst rd_a", 32'(rd_addr_a), 0);
        chk("mid rst bf_en", 32'(bf_enable), 0);
        chk("mid rst wr_en", 32'(wr_en), 0);
        chk("mid rst wr_a", 32'(wr_addr_a), 0);
        chk("mid rst wr_b", 32'(wr_addr_b), 0);
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            chk($sformatf("post rst wr_en %0d", c), 32'(wr_en), 0);
            chk($sformatf("post rst busy %0d", c), 32'(busy), 0);
        end
        run_pass("after rst", 100, 0);

        // Single-stage instance.
        @(negedge clk); start1 = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk); start1 = 1'b0; #1;
            chk($sformatf("s1 rd_en c%0d", c), 32'(rd_en1), 32'(c <= 4));
            if (c <= 4) begin
                chk($sformatf("s1 rd_a c%0d", c), 32'(rd_addr_a1), exp_a[c-1]);
                chk($sformatf("s1 rd_b c%0d", c), 32'(rd_addr_b1), exp_b[c-1]);
            end
            chk($sformatf("s1 bf_en c%0d", c), 32'(bf_enable1), 32'(c >= 2 && c <= 5));
            chk($sformatf("s1 wr_en c%0d", c), 32'(wr_en1), 32'(c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) begin
                chk($sformatf("s1 wr_a c%0d", c), 32'(wr_addr_a1), exp_a[c-3]);
                chk($sformatf("s1 wr_b c%0d", c), 32'(wr_addr_b1), exp_b[c-3]);
            end
            chk($sformatf("s1 done c%0d", c), 32'(done1), 32'(c == 7));
            chk($sformatf("s1 busy c%0d", c), 32'(busy1), 32'(c <= 7));
            chk($sformatf("s1 stage c%0d", c), 32'(stage1), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
